// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: holds architectural HI/LO and models fixed
// multi-cycle latency with a registered busy flag. Define MDU_MADD_EN to enable madd/maddu/msub.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [63:0]      pend, pend_nx;
  logic             commit, commit_nx;
  logic             busy_nx;
  logic [31:0]      hi_nx, lo_nx;

  logic        is_mul_c, is_div_c, is_mthi_c, is_mtlo_c, accept_c;
  logic        div_zero_c, neg_a_c, neg_b_c;
  logic [31:0] a_mag_c, b_mag_c, q_mag_c, r_mag_c, quo_c, rem_c;
  logic [63:0] prod_s_c, prod_u_c, result_c;

  // Request decode; madd family only counts as a valid op when the feature is built in
  always_comb begin
    is_mul_c  = (md_op == OP_MULT) || (md_op == OP_MULTU)
`ifdef MDU_MADD_EN
             || (md_op == OP_MADD) || (md_op == OP_MADDU) || (md_op == OP_MSUB)
`endif
             ;
    is_div_c  = (md_op == OP_DIV) || (md_op == OP_DIVU);
    is_mthi_c = (md_op == OP_MTHI);
    is_mtlo_c = (md_op == OP_MTLO);
    accept_c  = start && !req && !busy && (is_mul_c || is_div_c || is_mthi_c || is_mtlo_c);
  end

  // Products and a shared sign-magnitude divider (divisor forced to 1 on zero to stay defined)
  always_comb begin
    prod_s_c   = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    prod_u_c   = {32'b0, rs_data} * {32'b0, rt_data};
    div_zero_c = (rt_data == 32'd0);
    neg_a_c    = (md_op == OP_DIV) && rs_data[31];
    neg_b_c    = (md_op == OP_DIV) && rt_data[31];
    a_mag_c    = neg_a_c ? -rs_data : rs_data;
    b_mag_c    = div_zero_c ? 32'd1 : (neg_b_c ? -rt_data : rt_data);
    q_mag_c    = a_mag_c / b_mag_c;
    r_mag_c    = a_mag_c % b_mag_c;
    quo_c      = (neg_a_c ^ neg_b_c) ? -q_mag_c : q_mag_c;
    rem_c      = neg_a_c ? -r_mag_c : r_mag_c;
  end

  // Pending-result select; accumulate ops read HI/LO as of the accepting edge
  always_comb begin
    result_c = 64'd0;
    case (md_op)
      OP_MULT:  result_c = prod_s_c;
      OP_MULTU: result_c = prod_u_c;
      OP_DIV,
      OP_DIVU:  result_c = {rem_c, quo_c};
`ifdef MDU_MADD_EN
      OP_MADD:  result_c = {hi, lo} + prod_s_c;
      OP_MADDU: result_c = {hi, lo} + prod_u_c;
      OP_MSUB:  result_c = {hi, lo} - prod_s_c;
`endif
      default:  result_c = 64'd0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    pend_nx   = pend;
    commit_nx = commit;
    busy_nx   = busy;
    hi_nx     = hi;
    lo_nx     = lo;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (is_mthi_c) begin
            hi_nx = rs_data;
          end else if (is_mtlo_c) begin
            lo_nx = rs_data;
          end else begin
            state_nx  = S_RUN;
            busy_nx   = 1'b1;
            pend_nx   = result_c;
            commit_nx = !(is_div_c && div_zero_c);
            cnt_nx    = is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end
        end
      end
      S_RUN: begin
        if (cnt <= CNT_W'(1)) begin
          state_nx  = S_IDLE;
          busy_nx   = 1'b0;
          cnt_nx    = '0;
          pend_nx   = 64'd0;
          commit_nx = 1'b0;
          if (commit) begin
            hi_nx = pend[63:32];
            lo_nx = pend[31:0];
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pend   <= 64'd0;
      commit <= 1'b0;
      busy   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      pend   <= pend_nx;
      commit <= commit_nx;
      busy   <= busy_nx;
      hi     <= hi_nx;
      lo     <= lo_nx;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected {hi,lo} pushed at issue, popped when busy falls.
module tb_md_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;

  logic        clk = 1'b0;
  logic        reset, start, req;
  logic [3:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .req(req),
    .busy(busy), .hi(hi), .lo(lo)
  );

  // Drive one request for a single edge; returns 1 time unit after that edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; req = r;
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE; rs_data = 32'd0; rt_data = 32'd0; req = 1'b0;
  endtask

  // Count edges until busy falls (bounded); flags any HI/LO change while busy
  task automatic wait_idle(output int cycles, output bit stable);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; cycles = 0; stable = 1'b1;
    while (busy === 1'b1 && cycles < 200) begin
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; req = 1'b0; md_op = OP_NONE; rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult;
    logic [3:0]  ops [4] = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULT};
    logic [31:0] as  [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] bs  [4] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [63:0] exs [4] = '{64'hFFFFFFFF_FFFFFFFA, 64'hFFFFFFFE_00000001,
                             64'h00000000_00000001, 64'hC0000000_80000000};
    logic [63:0] exp;
    int cyc; bit stable;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exs[i]);
      issue(ops[i], as[i], bs[i], 1'b0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_rise[%0d]: got %b expected 1", i, busy); end
      wait_idle(cyc, stable);
      n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL mult_busy_cycles[%0d]: got %0d expected 5", i, cyc); end
      n_checks++; if (!stable) begin n_fail++; $display("FAIL mult_hold[%0d]: hi/lo changed while busy, got 1 expected 0", i); end
      exp = exp_q.pop_front();
      n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL mult_result[%0d]: got %h expected %h", i, {hi, lo}, exp); end
    end
  endtask

  task automatic test_div;
    logic [3:0]  ops [5] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
    logic [31:0] as  [5] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFF9};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd2};
    logic [63:0] exs [5] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_00000003, 64'h00000000_80000000,
                             64'h00000001_FFFFFFFD, 64'h00000001_7FFFFFFC};
    logic [63:0] exp;
    int cyc; bit stable;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exs[i]);
      issue(ops[i], as[i], bs[i], 1'b0);
      wait_idle(cyc, stable);
      n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL div_busy_cycles[%0d]: got %0d expected 10", i, cyc); end
      n_checks++; if (!stable) begin n_fail++; $display("FAIL div_hold[%0d]: hi/lo changed while busy, got 1 expected 0", i); end
      exp = exp_q.pop_front();
      n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, {hi, lo}, exp); end
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] h0, l0;
    issue(OP_MTHI, 32'h12345678, 32'd0, 1'b0);
    n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", busy); end
    issue(OP_MTLO, 32'h9ABCDEF0, 32'd0, 1'b0);
    n_checks++; if (lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 9abcdef0", lo); end
    n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", hi); end
    h0 = hi; l0 = lo;
    issue(OP_NONE, 32'hDEADBEEF, 32'd1, 1'b0);
    n_checks++; if ({busy, hi, lo} !== {1'b0, h0, l0}) begin n_fail++; $display("FAIL op_none: got %h expected %h", {busy, hi, lo}, {1'b0, h0, l0}); end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] exp;
    int cyc; bit stable;
    exp_q.push_back(64'h00000002_0000000E);
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk); start = 1'b1; md_op = OP_MULT; rs_data = 32'd3; rt_data = 32'd3;
    repeat (2) @(posedge clk);
    @(negedge clk); md_op = OP_MTHI; rs_data = 32'h55555555;
    @(posedge clk); #1; start = 1'b0; md_op = OP_NONE; rs_data = 32'd0; rt_data = 32'd0;
    wait_idle(cyc, stable);
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d expected 7", cyc); end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL ignore_hold: hi/lo changed while busy, got 1 expected 0"); end
    exp = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", {hi, lo}, exp); end
    repeat (8) @(posedge clk); #1;
    n_checks++; if ({busy, hi, lo} !== {1'b0, exp}) begin n_fail++; $display("FAIL ignore_no_late: got %h expected %h", {busy, hi, lo}, {1'b0, exp}); end
  endtask

  task automatic test_req;
    logic [31:0] h0, l0;
    logic [63:0] exp;
    int cyc; bit stable;
    h0 = hi; l0 = lo;
    issue(OP_MULT, 32'd5, 32'd5, 1'b1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_suppress_busy: got %b expected 0", busy); end
    repeat (6) @(posedge clk); #1;
    n_checks++; if ({hi, lo} !== {h0, l0}) begin n_fail++; $display("FAIL req_suppress_hilo: got %h expected %h", {hi, lo}, {h0, l0}); end
    exp_q.push_back(64'h00000000_0000002A);
    issue(OP_MULT, 32'd7, 32'd6, 1'b0);
    @(negedge clk); req = 1'b1;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    wait_idle(cyc, stable);
    n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL req_busy_cycles: got %0d expected 4", cyc); end
    exp = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL req_inflight_result: got %h expected %h", {hi, lo}, exp); end
  endtask

  task automatic test_div_zero;
    int cyc; bit stable;
    issue(OP_MTHI, 32'hA, 32'd0, 1'b0);
    issue(OP_MTLO, 32'hB, 32'd0, 1'b0);
    issue(OP_DIV, 32'd1234, 32'd0, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL divzero_busy_rise: got %b expected 1", busy); end
    wait_idle(cyc, stable);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL divzero_busy_cycles: got %0d expected 10", cyc); end
    n_checks++; if ({hi, lo} !== 64'h0000000A_0000000B) begin n_fail++; $display("FAIL divzero_hilo: got %h expected 0000000a0000000b", {hi, lo}); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] exp;
    int cyc; bit stable;
    issue(OP_DIV, 32'd100, 32'd3, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++; if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL reset_mid_async: got %h expected 0", {busy, hi, lo}); end
    @(negedge clk); reset = 1'b0;
    repeat (12) @(posedge clk); #1;
    n_checks++; if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL reset_mid_no_commit: got %h expected 0", {busy, hi, lo}); end
    exp_q.push_back(64'h00000000_0000000C);
    issue(OP_MULTU, 32'd3, 32'd4, 1'b0);
    wait_idle(cyc, stable);
    exp = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL reset_mid_recover: got %h expected %h", {hi, lo}, exp); end
  endtask

  task automatic test_madd;
    int cyc; bit stable;
    issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    begin
      logic [3:0]  ops [3] = '{OP_MADD, OP_MSUB, OP_MADDU};
      logic [31:0] as  [3] = '{32'd1, 32'd1, 32'hFFFFFFFF};
      logic [31:0] bs  [3] = '{32'd1, 32'd1, 32'd2};
      logic [63:0] exs [3] = '{64'h00000001_00000000, 64'h00000000_FFFFFFFF, 64'h00000002_FFFFFFFD};
      logic [63:0] exp;
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(exs[i]);
        issue(ops[i], as[i], bs[i], 1'b0);
        wait_idle(cyc, stable);
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL madd_busy_cycles[%0d]: got %0d expected 5", i, cyc); end
        exp = exp_q.pop_front();
        n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL madd_result[%0d]: got %h expected %h", i, {hi, lo}, exp); end
      end
    end
`else
    issue(OP_MADD, 32'd1, 32'd1, 1'b0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL madd_off_busy: got %b expected 0", busy); end
    wait_idle(cyc, stable);
    repeat (6) @(posedge clk); #1;
    n_checks++; if ({busy, hi, lo} !== {1'b0, 64'h00000000_FFFFFFFF}) begin n_fail++; $display("FAIL madd_off_hilo: got %h expected 000000000ffffffff", {busy, hi, lo}); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_req();
    test_div_zero();
    test_reset_mid();
    test_madd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
